// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges the instruction and data sram-like channels onto
// one shared sram-like master port. Data has fixed priority over instruction
// in IDLE; a presented-but-unaccepted request locks the grant until its
// address handshake. An in-order owner FIFO steers each returning response
// back to the channel that issued it.
module sram_like_arbiter #(
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  // Pointer width is kept at least 1 bit so OUTSTANDING=1 still elaborates;
  // in that case the pointers are simply held at zero.
  localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(OUTSTANDING) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CW-1:0]          count;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [OUTSTANDING-1:0] owner_q;

  logic full;
  logic empty;
  logic sel_data;
  logic cand_req;
  logic push;
  logic pop;
  logic head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (OUTSTANDING == 1) return '0;
    return p + PW'(1);
  endfunction

  // Grant selection: priority pick in IDLE, pinned requester while locked.
  always_comb begin
    full     = (count == CW'(OUTSTANDING));
    empty    = (count == '0);
    sel_data = 1'b0;
    cand_req = 1'b0;
    case (state)
      LOCK_I: begin
        sel_data = 1'b0;
        cand_req = inst_req;
      end
      LOCK_D: begin
        sel_data = 1'b1;
        cand_req = data_req;
      end
      default: begin
        sel_data = data_req;
        cand_req = data_req | inst_req;
      end
    endcase
  end

  // Master-side mux; everything except rdata is held at zero during reset.
  always_comb begin
    m_req   = cand_req & ~full & ~rst;
    m_wr    = 1'b0;
    m_size  = '0;
    m_addr  = '0;
    m_wdata = '0;
    if (!rst) begin
      if (sel_data) begin
        m_wr    = data_wr;
        m_size  = data_size;
        m_addr  = data_addr;
        m_wdata = data_wdata;
      end else begin
        m_wr    = inst_wr;
        m_size  = inst_size;
        m_addr  = inst_addr;
        m_wdata = inst_wdata;
      end
    end
  end

  // Handshake/response decode and fan-out to the two requesters.
  always_comb begin
    push         = m_req & m_addr_ok;
    // A response arriving with nothing outstanding is dropped.
    pop          = m_data_ok & ~empty & ~rst;
    head         = owner_q[rd_ptr];
    inst_addr_ok = push & ~sel_data;
    data_addr_ok = push & sel_data;
    inst_data_ok = pop & ~head;
    data_data_ok = pop & head;
    inst_rdata   = m_rdata;
    data_rdata   = m_rdata;
  end

  // Next grant state: lock on a presented-but-refused request, release on handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m_req && !m_addr_ok) state_nxt = sel_data ? LOCK_D : LOCK_I;
      end
      LOCK_I, LOCK_D: begin
        if (push) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Owner FIFO and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      owner_q <= '0;
    end else begin
      if (push) begin
        owner_q[wr_ptr] <= sel_data;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter (OUTSTANDING=2). Inputs change on the
// falling edge; combinational outputs are checked 1ns later.
module tb_sram_like_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;

  int unsigned n_pass;
  int unsigned n_total;

  localparam logic [31:0] A_I  = 32'h1FC0_0000;
  localparam logic [31:0] A_D  = 32'h0000_8000;
  localparam logic [31:0] A_D1 = 32'h0000_8004;
  localparam logic [31:0] A_D2 = 32'h0000_8008;

  sram_like_arbiter #(.OUTSTANDING(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .m_req        (m_req),
    .m_wr         (m_wr),
    .m_size       (m_size),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_addr_ok    (m_addr_ok),
    .m_data_ok    (m_data_ok),
    .m_rdata      (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = A_I; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = A_D; data_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  // Advance to the next falling edge (inputs are then driven by the caller).
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    clear_inputs();

    // Reset: outputs gated even with a request and slave accept present.
    step();
    inst_req = 1; inst_wr = 1; m_addr_ok = 1; m_data_ok = 1;
    #1;
    check("rst_m_req", 32'(m_req), 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wr", 32'(m_wr), 0);
    check("rst_inst_addr_ok", 32'(inst_addr_ok), 0);
    check("rst_inst_data_ok", 32'(inst_data_ok), 0);
    step();
    clear_inputs();
    rst = 1'b0;
    #1;
    check("rst_count", 32'(dut.count), 0);

    // 1: single inst read, data_ok two cycles after the handshake.
    step(); inst_req = 1; m_addr_ok = 1; #1;
    check("t1_m_req", 32'(m_req), 1);
    check("t1_m_addr", m_addr, A_I);
    check("t1_inst_addr_ok", 32'(inst_addr_ok), 1);
    check("t1_data_addr_ok", 32'(data_addr_ok), 0);
    step(); clear_inputs(); #1;
    check("t1_no_early_data_ok", 32'(inst_data_ok), 0);
    step(); m_data_ok = 1; m_rdata = 32'hBFC0_0000; #1;
    check("t1_inst_data_ok", 32'(inst_data_ok), 1);
    check("t1_inst_rdata", inst_rdata, 32'hBFC0_0000);
    check("t1_data_data_ok", 32'(data_data_ok), 0);
    step(); clear_inputs(); #1;
    check("t1_count", 32'(dut.count), 0);

    // 2: simultaneous requests, data first, responses steered D then I.
    step(); inst_req = 1; data_req = 1; m_addr_ok = 1; #1;
    check("t2_m_addr_d", m_addr, A_D);
    check("t2_data_addr_ok", 32'(data_addr_ok), 1);
    check("t2_inst_addr_ok0", 32'(inst_addr_ok), 0);
    step(); data_req = 0; #1;
    check("t2_m_addr_i", m_addr, A_I);
    check("t2_inst_addr_ok", 32'(inst_addr_ok), 1);
    step(); clear_inputs(); m_data_ok = 1; m_rdata = 32'h1111_1111; #1;
    check("t2_resp1_data", 32'(data_data_ok), 1);
    check("t2_resp1_inst", 32'(inst_data_ok), 0);
    check("t2_resp1_rdata", data_rdata, 32'h1111_1111);
    step(); m_rdata = 32'h2222_2222; #1;
    check("t2_resp2_inst", 32'(inst_data_ok), 1);
    check("t2_resp2_data", 32'(data_data_ok), 0);
    step(); clear_inputs(); #1;
    check("t2_count", 32'(dut.count), 0);

    // 3: inst refused for 3 cycles, data rises meanwhile but waits.
    step(); inst_req = 1; #1;
    check("t3_c0_m_addr", m_addr, A_I);
    check("t3_c0_inst_addr_ok", 32'(inst_addr_ok), 0);
    step(); data_req = 1; #1;
    check("t3_c1_m_addr", m_addr, A_I);
    step(); #1;
    check("t3_c2_m_addr", m_addr, A_I);
    step(); m_addr_ok = 1; #1;
    check("t3_c3_m_addr", m_addr, A_I);
    check("t3_c3_inst_addr_ok", 32'(inst_addr_ok), 1);
    check("t3_c3_data_addr_ok", 32'(data_addr_ok), 0);
    step(); inst_req = 0; #1;
    check("t3_c4_m_addr", m_addr, A_D);
    check("t3_c4_data_addr_ok", 32'(data_addr_ok), 1);
    step(); clear_inputs(); m_data_ok = 1; #1;
    check("t3_resp1_inst", 32'(inst_data_ok), 1);
    step(); #1;
    check("t3_resp2_data", 32'(data_data_ok), 1);
    step(); clear_inputs(); #1;
    check("t3_count", 32'(dut.count), 0);

    // 4: FIFO full blocks the third read until a pop frees a slot.
    step(); data_req = 1; data_addr = A_D; m_addr_ok = 1; #1;
    check("t4_d0_addr_ok", 32'(data_addr_ok), 1);
    step(); data_addr = A_D1; #1;
    check("t4_d1_addr_ok", 32'(data_addr_ok), 1);
    step(); data_addr = A_D2; #1;
    check("t4_full_count", 32'(dut.count), 2);
    check("t4_full_m_req", 32'(m_req), 0);
    check("t4_full_addr_ok", 32'(data_addr_ok), 0);
    step(); m_data_ok = 1; #1;
    check("t4_pop_m_req", 32'(m_req), 0);
    check("t4_pop_addr_ok", 32'(data_addr_ok), 0);
    check("t4_pop_data_ok", 32'(data_data_ok), 1);
    step(); m_data_ok = 0; #1;
    check("t4_d2_m_req", 32'(m_req), 1);
    check("t4_d2_m_addr", m_addr, A_D2);
    check("t4_d2_addr_ok", 32'(data_addr_ok), 1);
    step(); clear_inputs(); #1;
    check("t4_count_after", 32'(dut.count), 2);
    step(); m_data_ok = 1; #1;
    step(); #1;
    check("t4_drain_last", 32'(data_data_ok), 1);
    step(); clear_inputs(); #1;
    check("t4_count_drained", 32'(dut.count), 0);

    // 5: I, D, I, D issue with back-to-back responses, incl. push+pop cycles.
    step(); inst_req = 1; m_addr_ok = 1; #1;
    check("t5_i0_addr_ok", 32'(inst_addr_ok), 1);
    step(); inst_req = 0; data_req = 1; #1;
    check("t5_d0_addr_ok", 32'(data_addr_ok), 1);
    step(); data_req = 0; m_data_ok = 1; #1;
    check("t5_r0_inst", 32'(inst_data_ok), 1);
    check("t5_r0_data", 32'(data_data_ok), 0);
    step(); inst_req = 1; #1;
    check("t5_r1_data", 32'(data_data_ok), 1);
    check("t5_r1_inst", 32'(inst_data_ok), 0);
    check("t5_i1_addr_ok", 32'(inst_addr_ok), 1);
    step(); inst_req = 0; data_req = 1; #1;
    check("t5_r2_inst", 32'(inst_data_ok), 1);
    check("t5_d1_addr_ok", 32'(data_addr_ok), 1);
    check("t5_mid_count", 32'(dut.count), 1);
    step(); data_req = 0; #1;
    check("t5_r3_data", 32'(data_data_ok), 1);
    check("t5_r3_inst", 32'(inst_data_ok), 0);
    step(); clear_inputs(); #1;
    check("t5_count", 32'(dut.count), 0);

    // 6: reset with two outstanding, stray responses are dropped.
    step(); inst_req = 1; m_addr_ok = 1; #1;
    step(); inst_req = 0; data_req = 1; #1;
    step(); clear_inputs(); #1;
    check("t6_pre_count", 32'(dut.count), 2);
    rst = 1;
    inst_req = 1; m_addr_ok = 1; #1;
    check("t6_rst_m_req", 32'(m_req), 0);
    check("t6_rst_addr_ok", 32'(inst_addr_ok), 0);
    step(); rst = 0; clear_inputs(); m_data_ok = 1; #1;
    check("t6_stray1_inst", 32'(inst_data_ok), 0);
    check("t6_stray1_data", 32'(data_data_ok), 0);
    step(); #1;
    check("t6_stray2_inst", 32'(inst_data_ok), 0);
    check("t6_stray2_data", 32'(data_data_ok), 0);
    step(); clear_inputs(); #1;
    check("t6_count", 32'(dut.count), 0);
    data_req = 1; m_addr_ok = 1; #1;
    check("t6_new_m_req", 32'(m_req), 1);
    check("t6_new_addr_ok", 32'(data_addr_ok), 1);
    step(); clear_inputs(); m_data_ok = 1; m_rdata = 32'hCAFE_0001; #1;
    check("t6_new_data_ok", 32'(data_data_ok), 1);
    check("t6_new_rdata", data_rdata, 32'hCAFE_0001);
    step(); clear_inputs(); #1;
    check("t6_final_count", 32'(dut.count), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
